// File: rtl/alu_mdu_if.sv
// Execute-stage ALU operand/result bus plus the multiply/divide start/busy/done handshake.
interface alu_mdu_if #(parameter int WIDTH = 32);
    logic [3:0]       alu_control;
    logic [WIDTH-1:0] data_a;
    logic [WIDTH-1:0] data_b;
    logic [WIDTH-1:0] alu_result;
    logic             zero_sig;
    logic             overflow;
    logic             md_start;
    logic [1:0]       md_op;
    logic             md_cancel;
    logic             hi_we;
    logic             lo_we;
    logic             md_busy;
    logic             md_done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output alu_control, data_a, data_b, md_start, md_op, md_cancel, hi_we, lo_we,
        input  alu_result, zero_sig, overflow, md_busy, md_done, hi, lo
    );

    modport slave (
        input  alu_control, data_a, data_b, md_start, md_op, md_cancel, hi_we, lo_we,
        output alu_result, zero_sig, overflow, md_busy, md_done, hi, lo
    );
endinterface

// File: rtl/alu_mdu.sv
// Execute-stage ALU (combinational, zero latency) plus iterative mul/div owning HI/LO.
// MDU result lands WIDTH+1 edges after accept; md_busy stalls the pipe and starts while busy are dropped.
module alu_mdu #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_mdu_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    logic [WIDTH-1:0] a, b, res, sum, diff;
    logic [SHW-1:0]   shamt;
    logic             ovf;

    assign a     = bus.data_a;
    assign b     = bus.data_b;
    assign shamt = a[SHW-1:0];
    assign sum   = a + b;
    assign diff  = a - b;

    always_comb begin
        res = '0;
        ovf = 1'b0;
        case (bus.alu_control)
            4'b0000: res = a & b;
            4'b0001: res = a | b;
            4'b0010: begin
                res = sum;
                ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            4'b0110: begin
                res = diff;
                ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            4'b0111: res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            4'b1000: res = {{(WIDTH-1){1'b0}}, a < b};
            4'b1100: res = ~(a | b);
            4'b0011: res = a ^ b;
            4'b1001: res = b << shamt;
            4'b1010: res = b >> shamt;
            4'b1011: res = $unsigned($signed(b) >>> shamt);
            4'b0100: res = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            default: res = '0;
        endcase
    end

    assign bus.alu_result = res;
    assign bus.zero_sig   = (res == '0);
    assign bus.overflow   = ovf;

    // Iterate on magnitudes; signs are reapplied in FIX.
    state_t             state;
    logic [SHW-1:0]     cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opb, hi_q, lo_q;
    logic               busy_q, done_q, div_op, neg_q, neg_r;

    logic               signed_op, sa, sb;
    logic [WIDTH-1:0]   abs_a, abs_b;

    assign signed_op = ~bus.md_op[0];
    assign sa        = signed_op & a[WIDTH-1];
    assign sb        = signed_op & b[WIDTH-1];
    assign abs_a     = sa ? -a : a;
    assign abs_b     = sb ? -b : b;

    // acc upper half: partial product / remainder; lower half: multiplier / dividend->quotient.
    logic [WIDTH:0]     mul_sum, div_part;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem, q_fix, r_fix;
    logic [2*WIDTH-1:0] acc_nxt, prod_fix;

    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    assign div_part = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_ge   = div_part >= {1'b0, opb};
    assign div_rem  = div_ge ? (div_part[WIDTH-1:0] - opb) : div_part[WIDTH-1:0];
    assign acc_nxt  = div_op ? {div_rem, acc[WIDTH-2:0], div_ge}
                             : {mul_sum, acc[WIDTH-1:1]};
    assign prod_fix = neg_q ? -acc : acc;
    assign q_fix    = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign r_fix    = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            opb    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            div_op <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.hi_we) hi_q <= a;
                    if (bus.lo_we) lo_q <= a;
                    if (bus.md_start && !bus.md_cancel) begin
                        state  <= CALC;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        acc    <= {{WIDTH{1'b0}}, abs_a};
                        opb    <= abs_b;
                        div_op <= bus.md_op[1];
                        neg_q  <= sa ^ sb;
                        neg_r  <= sa;
                    end
                end
                CALC: begin
                    if (bus.md_cancel) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        cnt    <= '0;
                    end else begin
                        acc <= acc_nxt;
                        cnt <= cnt + 1'b1;
                        if (cnt == SHW'(WIDTH-1)) state <= FIX;
                    end
                end
                FIX: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    cnt    <= '0;
                    if (!bus.md_cancel) begin
                        done_q <= 1'b1;
                        if (div_op) begin
                            // Divide by zero: all-ones quotient, remainder restores the dividend.
                            lo_q <= (opb == '0) ? '1 : q_fix;
                            hi_q <= r_fix;
                        end else begin
                            {hi_q, lo_q} <= prod_fix;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.md_busy = busy_q;
    assign bus.md_done = done_q;
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;
endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu: WIDTH=32 and WIDTH=16 instances, directed vectors.
module tb_alu_mdu;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    alu_mdu_if #(.WIDTH(32)) b32();
    alu_mdu_if #(.WIDTH(16)) b16();

    alu_mdu #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
    alu_mdu #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));

    typedef struct {string name; logic [31:0] res; logic z; logic o;} alu_exp_t;
    typedef struct {logic [31:0] hi; logic [31:0] lo; int done_cyc;} md_exp_t;

    alu_exp_t alu_q[$];
    md_exp_t  q32[$];
    md_exp_t  q16[$];
    alu_exp_t ae;
    md_exp_t  me32, me16;
    logic     alu_vld = 1'b0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Monitor: compares whatever the DUTs present against queued expectations.
    always @(negedge clk) begin
        if (alu_vld && alu_q.size() > 0) begin
            ae = alu_q.pop_front();
            chk({ae.name, "_res"}, b32.alu_result, ae.res);
            chk({ae.name, "_zero"}, b32.zero_sig, ae.z);
            chk({ae.name, "_ovf"}, b32.overflow, ae.o);
        end
        if (b32.md_done) begin
            if (q32.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL md_done32: unexpected pulse hi=%h lo=%h", b32.hi, b32.lo);
            end else begin
                me32 = q32.pop_front();
                chk("hi32", b32.hi, me32.hi);
                chk("lo32", b32.lo, me32.lo);
                chk("latency32", cyc, me32.done_cyc);
            end
        end
        if (b16.md_done) begin
            if (q16.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL md_done16: unexpected pulse hi=%h lo=%h", b16.hi, b16.lo);
            end else begin
                me16 = q16.pop_front();
                chk("hi16", {16'h0, b16.hi}, me16.hi);
                chk("lo16", {16'h0, b16.lo}, me16.lo);
                chk("latency16", cyc, me16.done_cyc);
            end
        end
    end

    task automatic alu(input string name, input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input logic z, input logic o);
        @(posedge clk); #1;
        b32.alu_control = ctl;
        b32.data_a = a;
        b32.data_b = b;
        alu_q.push_back('{name, r, z, o});
        alu_vld = 1'b1;
        @(posedge clk); #1;
        alu_vld = 1'b0;
    endtask

    task automatic issue32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eh, input logic [31:0] el, input bit push, input bit now);
        if (!now) begin
            @(posedge clk); #1;
        end
        b32.md_op = op;
        b32.data_a = a;
        b32.data_b = b;
        b32.md_start = 1'b1;
        if (push) q32.push_back('{eh, el, cyc + 34});
        chk("busy_at_start32", b32.md_busy, 1'b0);
        @(posedge clk); #1;
        b32.md_start = 1'b0;
    endtask

    task automatic issue16(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] eh, input logic [15:0] el);
        @(posedge clk); #1;
        b16.md_op = op;
        b16.data_a = a;
        b16.data_b = b;
        b16.md_start = 1'b1;
        q16.push_back('{{16'h0, eh}, {16'h0, el}, cyc + 18});
        @(posedge clk); #1;
        b16.md_start = 1'b0;
    endtask

    task automatic wait_done(input string name, input bit w16);
        bit seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (w16 ? b16.md_done : b32.md_done) seen = 1'b1;
        end
        chk(name, seen, 1'b1);
    endtask

    logic [33:0] prof;

    initial begin
        b32.alu_control = '0; b32.data_a = '0; b32.data_b = '0; b32.md_start = 0;
        b32.md_op = '0; b32.md_cancel = 0; b32.hi_we = 0; b32.lo_we = 0;
        b16.alu_control = '0; b16.data_a = '0; b16.data_b = '0; b16.md_start = 0;
        b16.md_op = '0; b16.md_cancel = 0; b16.hi_we = 0; b16.lo_we = 0;

        repeat (2) @(negedge clk);
        chk("rst_hi", b32.hi, 32'h0);
        chk("rst_lo", b32.lo, 32'h0);
        chk("rst_busy", b32.md_busy, 1'b0);
        chk("rst_done", b32.md_done, 1'b0);
        rst_n = 1'b1;

        alu("add_ovf",  4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 1);
        alu("add",      4'b0010, 32'h00000001, 32'h00000002, 32'h00000003, 0, 0);
        alu("sub_zero", 4'b0110, 32'h00000005, 32'h00000005, 32'h00000000, 1, 0);
        alu("sub_ovf",  4'b0110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 0, 1);
        alu("slt",      4'b0111, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 0, 0);
        alu("sltu",     4'b1000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 0);
        alu("sra",      4'b1011, 32'h00000004, 32'h80000000, 32'hF8000000, 0, 0);
        alu("srl",      4'b1010, 32'h00000004, 32'h80000000, 32'h08000000, 0, 0);
        alu("sll_mask", 4'b1001, 32'h00000024, 32'h00000001, 32'h00000010, 0, 0);
        alu("lui",      4'b0100, 32'h00000000, 32'h00001234, 32'h12340000, 0, 0);
        alu("and",      4'b0000, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 0, 0);
        alu("or",       4'b0001, 32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 0, 0);
        alu("nor",      4'b1100, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 0, 0);
        alu("xor",      4'b0011, 32'h0000FF00, 32'h00000FF0, 32'h0000F0F0, 0, 0);
        alu("illegal",  4'b1111, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1, 0);

        // mult with per-cycle busy profile: 33 busy cycles, then idle on the done cycle.
        issue32(2'b00, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 1, 0);
        for (int k = 0; k < 34; k++) begin
            @(negedge clk);
            prof[k] = b32.md_busy;
        end
        chk("busy_profile", prof, 34'h1FFFFFFFF);

        issue32(2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1, 0);
        wait_done("done_div_neg", 0);
        issue32(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1, 0);
        wait_done("done_div_min", 0);
        issue32(2'b11, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 1, 0);
        wait_done("done_divu_zero", 0);

        // mthi/mtlo, then a cancelled multu must leave them intact.
        @(posedge clk); #1;
        b32.data_a = 32'hAAAA5555; b32.hi_we = 1;
        @(posedge clk); #1;
        b32.hi_we = 0; b32.data_a = 32'h1234ABCD; b32.lo_we = 1;
        @(posedge clk); #1;
        b32.lo_we = 0;
        chk("mthi", b32.hi, 32'hAAAA5555);
        chk("mtlo", b32.lo, 32'h1234ABCD);
        issue32(2'b01, 32'h12345678, 32'h9ABCDEF0, 0, 0, 0, 0);
        b32.data_a = 32'hDEADBEEF; b32.hi_we = 1;
        @(posedge clk); #1;
        b32.hi_we = 0;
        chk("hi_we_busy", b32.hi, 32'hAAAA5555);
        repeat (9) @(posedge clk);
        #1 b32.md_cancel = 1;
        @(posedge clk); #1;
        b32.md_cancel = 0;
        chk("cancel_busy", b32.md_busy, 1'b0);
        chk("cancel_hi", b32.hi, 32'hAAAA5555);
        chk("cancel_lo", b32.lo, 32'h1234ABCD);
        issue32(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1, 0);
        wait_done("done_after_cancel", 0);

        // A start arriving mid-operation must not restart the divide.
        issue32(2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1, 0);
        repeat (5) @(posedge clk);
        #1 b32.md_start = 1; b32.md_op = 2'b11; b32.data_a = 32'd50; b32.data_b = 32'd0;
        @(posedge clk); #1;
        b32.md_start = 0;
        wait_done("done_start_busy", 0);

        @(posedge clk); #1;
        b32.md_start = 1; b32.md_cancel = 1;
        @(posedge clk); #1;
        b32.md_start = 0; b32.md_cancel = 0;
        chk("start_cancel_busy", b32.md_busy, 1'b0);
        repeat (40) @(posedge clk);

        issue32(2'b00, 32'hFFFFFFF9, 32'h00000006, 32'hFFFFFFFF, 32'hFFFFFFD6, 1, 0);
        wait_done("done_b2b_first", 0);
        issue32(2'b11, 32'd100, 32'd9, 32'd1, 32'd11, 1, 1);
        wait_done("done_b2b_second", 0);

        issue32(2'b10, 32'd1000, 32'd3, 0, 0, 0, 0);
        repeat (8) @(posedge clk);
        #1 rst_n = 0;
        #2;
        chk("rst_mid_hi", b32.hi, 32'h0);
        chk("rst_mid_lo", b32.lo, 32'h0);
        chk("rst_mid_busy", b32.md_busy, 1'b0);
        @(negedge clk);
        rst_n = 1;
        repeat (40) @(posedge clk);

        issue16(2'b11, 16'hFFFF, 16'h0010, 16'h000F, 16'h0FFF);
        wait_done("done16_divu", 1);
        issue16(2'b10, 16'hFFF9, 16'h0002, 16'hFFFF, 16'hFFFD);
        wait_done("done16_div", 1);

        repeat (3) @(posedge clk);
        chk("q32_drained", q32.size(), 0);
        chk("q16_drained", q16.size(), 0);
        chk("alu_q_drained", alu_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised execute-stage arithmetic unit. Single-cycle combinational ALU path with 12 operations plus signed overflow detection, alongside an iterative multiply/divide unit (MDU). The MDU owns the architectural HI/LO registers and uses a start/busy/done handshake. Sits in EX; the pipeline stalls on `md_busy`.

## Interface
- `WIDTH`, 32: datapath width; must be even and ≥ 8.
- `SHW`, $clog2(WIDTH): shift-amount width (derived, not overridden).
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: reset; asynchronous, active-low.
- `alu_control` in 4: ALU operation select.
- `data_a` in WIDTH: operand A; for shifts, `data_a[SHW-1:0]` is the shift amount.
- `data_b` in WIDTH: operand B; for shifts, the value shifted.
- `alu_result` out WIDTH: combinational ALU result.
- `zero_sig` out 1: `alu_result` == 0.
- `overflow` out 1: signed overflow on add/sub; 0 for all other ops.
- `md_start` in 1: request an MDU op using `data_a`/`data_b`.
- `md_op` in 2: 00 mult, 01 multu, 10 div, 11 divu.
- `md_cancel` in 1: abort the in-flight MDU op (exception flush).
- `hi_we`, `lo_we` in 1: direct writes of `data_a` into HI/LO (mthi/mtlo).
- `md_busy` out 1: MDU occupied.
- `md_done` out 1: one-cycle pulse; HI/LO updated.
- `hi`, `lo` out WIDTH: HI/LO register contents.

## Operation
- ALU encodings:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB (A−B)
  - 0111 SLT (signed, result 1/0)
  - 1000 SLTU
  - 1100 NOR
  - 0011 XOR
  - 1001 SLL B by A[SHW-1:0]
  - 1010 SRL
  - 1011 SRA
  - 0100 LUI: `{B[WIDTH/2-1:0], WIDTH/2 zeros}`
  - All others give result 0.
- `overflow` for ADD: operands share a sign and the result sign differs. For SUB: operand signs differ and the result sign differs from A. The result is still produced; the exception is raised downstream.
- MDU FSM states are IDLE, CALC, FIX.
  - IDLE → CALC: on `md_start` with `md_cancel`=0. Latch absolute values (signed ops) or raw values (unsigned ops), operand signs, and op.
  - CALC: runs exactly WIDTH iterations, driven by a counter 0..WIDTH-1.
    - Multiply: shift-add, 2·WIDTH-bit accumulator.
    - Divide: restoring, one quotient bit per cycle.
  - CALC → FIX: after the last iteration.
  - FIX: applies sign correction and writes HI/LO, then returns to IDLE.
- Multiply result: `{HI,LO}` = full 2·WIDTH-bit product. mult negates the product if the operand signs differ.
- Divide result: LO = quotient, HI = remainder.
  - Signed: quotient is negative iff the signs differ; remainder takes the sign of the dividend.
  - MIN/−1 gives LO=MIN, HI=0 with no flag.
- Divide by zero (div or divu): LO = all ones, HI = `data_a` as latched.
- `md_start` while busy: ignored.
- `md_cancel` in CALC or FIX: return to IDLE, HI/LO unchanged, no `md_done`. `md_cancel` together with `md_start` in IDLE: start ignored.
- `hi_we`/`lo_we` while `md_busy`=1: ignored. In IDLE: write takes effect at the next edge. If a write lands on the same edge as FIX, the FIX write wins (it cannot occur while busy, so this is documented only).

## Timing
- Reset (async assert, sync release internally not required):
  - State IDLE, counter 0.
  - HI=0, LO=0, `md_busy`=0, `md_done`=0.
  - ALU outputs remain combinational.
- ALU path: zero latency, combinational from inputs.
- MDU: `md_start` sampled at edge E0. Then WIDTH CALC edges (E1..E_WIDTH), then the FIX edge E_WIDTH+1.
- `md_busy` = 1 in every cycle after E0 up to and including the cycle before E_WIDTH+1. It is registered; it is not high in the cycle `md_start` is presented.
- After E_WIDTH+1:
  - `md_done`=1 for exactly one cycle.
  - HI/LO show the new value in that same cycle.
  - `md_busy`=0, so a new `md_start` may be accepted at the next edge (back-to-back).
- Total latency is WIDTH+1 edges from the accepting edge; 33 for WIDTH=32.
- Reset asserted mid-operation: immediate return to IDLE; HI/LO cleared.

## Test plan
- ALU sweep (WIDTH=32), all of:
  - ADD 0x7FFFFFFF+1 → 0x80000000, overflow=1.
  - SUB 5−5 → 0, zero_sig=1.
  - SLT 0xFFFFFFFF<1 → 1; SLTU → 0.
  - SRA B=0x80000000, A=4 → 0xF8000000.
  - LUI B=0x1234 → 0x12340000.
- mult: 0xFFFFFFFE × 3 → HI=0xFFFFFFFF, LO=0xFFFFFFFA. `md_done` exactly 33 edges after accept; `md_busy` profile checked each cycle.
- div: −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/0 → LO=0xFFFFFFFF, HI=7. div 0x80000000/−1 → LO=0x80000000, HI=0.
- Cancel at iteration 10 of multu: no `md_done`, HI/LO keep their prior mtlo/mthi values. An immediate new start completes normally.
- Protocol corners, all of:
  - `md_start` while busy: ignored.
  - `hi_we` while busy: ignored.
  - Start+cancel together: no op.
  - Back-to-back starts on the `md_done` cycle: second result correct.
  - `rst_n` pulsed mid-divide: HI=LO=0, busy=0.
- WIDTH=16 instance: divu 0xFFFF/0x0010 → LO=0x0FFF, HI=0x000F, done after 17 edges.
